// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and helpers for the two-master data-memory
//               arbiter (master ids, lock states, beat-counter sizing).
//               Optional build macro: MEM_ARB_FIXED_PRIO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic {
        MST_CPU = 1'b0,
        MST_EXT = 1'b1
    } mst_id_t;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    localparam int unsigned C_MAX_LOCK_DEF = 8;
    localparam int unsigned C_BEAT_W_DEF   = $clog2(C_MAX_LOCK_DEF + 1);

    // Width of a counter that must hold the values 0..max_lock inclusive.
    function automatic int unsigned beat_width(input int unsigned max_lock);
        return $clog2(max_lock + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Master-side request/response bus and memory-side strobe bus
//               of the data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) ();

    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic          m0_rvalid;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_lock;
    logic          m1_gnt;
    logic          m1_rvalid;

    logic [DW-1:0] rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Arbiter view
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        input  mem_rdata,
        output m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // Requester / memory-model view
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        output mem_rdata,
        input  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pick
// Description : Combinational grant selector: requests, round-robin pointer
//               and lock status in, one-hot-or-zero grants out.
//               Build macro MEM_ARB_FIXED_PRIO_EN: master 0 wins conflicts.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  wire logic     i_req0,
    input  wire logic     i_req1,
`ifndef MEM_ARB_FIXED_PRIO_EN
    input  var  mst_id_t  i_rr,
`endif
    input  wire logic     i_lock_active,
    output logic          o_gnt0,
    output logic          o_gnt1
);

    always_comb begin
        o_gnt0 = 1'b0;
        o_gnt1 = 1'b0;
        if (i_lock_active) begin
            o_gnt1 = i_req1;
        end else if (i_req0 && i_req1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            o_gnt0 = 1'b1;
`else
            if (i_rr == MST_CPU) begin
                o_gnt0 = 1'b1;
            end else begin
                o_gnt1 = 1'b1;
            end
`endif
        end else begin
            o_gnt0 = i_req0;
            o_gnt1 = i_req1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-master pipelined arbiter in front of the single-port data
//               memory; round-robin with optional master-1 burst lock.
//               Build macro MEM_ARB_FIXED_PRIO_EN: fixed master-0 priority.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_LOCK = 8
) (
    input  wire logic     clk,
    input  wire logic     reset,
    mem_arbiter_if.slave  bus
);

    localparam int unsigned          C_BEAT_W    = beat_width(MAX_LOCK);
    localparam logic [C_BEAT_W-1:0]  C_MAX_BEATS = C_BEAT_W'(MAX_LOCK);
    localparam logic [C_BEAT_W-1:0]  C_ONE_BEAT  = C_BEAT_W'(1);

    lock_state_t          r_lock_state;
    lock_state_t          w_lock_state_nxt;
    logic [C_BEAT_W-1:0]  r_beats;
    logic [C_BEAT_W-1:0]  w_beats_nxt;

    logic w_max_exit;
    logic w_lock_active;
    logic w_pick_gnt0;
    logic w_pick_gnt1;
    logic w_gnt0;
    logic w_gnt1;
    logic w_acc0;
    logic w_acc1;

    logic          r_mem_en;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    mst_id_t       r_mst;
    logic          r_rvalid0;
    logic          r_rvalid1;

    // Exit conditions are evaluated in the current cycle so a released lock
    // already arbitrates under normal rules in that same cycle.
    assign w_max_exit    = (r_lock_state == LOCKED) && (r_beats >= C_MAX_BEATS);
    assign w_lock_active = (r_lock_state == LOCKED) && bus.m1_req && bus.m1_lock
                           && !w_max_exit;

`ifndef MEM_ARB_FIXED_PRIO_EN
    mst_id_t r_rr;
    mst_id_t w_rr_eff;
    mst_id_t w_rr_nxt;

    assign w_rr_eff = w_max_exit ? MST_CPU : r_rr;

    always_comb begin
        w_rr_nxt = w_rr_eff;
        if (w_acc0) begin
            w_rr_nxt = MST_EXT;
        end else if (w_acc1) begin
            w_rr_nxt = MST_CPU;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr <= MST_CPU;
        end else begin
            r_rr <= w_rr_nxt;
        end
    end
`endif

    mem_arb_pick u_pick (
        .i_req0        (bus.m0_req),
        .i_req1        (bus.m1_req),
`ifndef MEM_ARB_FIXED_PRIO_EN
        .i_rr          (w_rr_eff),
`endif
        .i_lock_active (w_lock_active),
        .o_gnt0        (w_pick_gnt0),
        .o_gnt1        (w_pick_gnt1)
    );

    assign w_gnt0     = w_pick_gnt0 & reset;
    assign w_gnt1     = w_pick_gnt1 & reset;
    assign w_acc0     = bus.m0_req & w_gnt0;
    assign w_acc1     = bus.m1_req & w_gnt1;
    assign bus.m0_gnt = w_gnt0;
    assign bus.m1_gnt = w_gnt1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lock_state <= UNLOCKED;
            r_beats      <= '0;
        end else begin
            r_lock_state <= w_lock_state_nxt;
            r_beats      <= w_beats_nxt;
        end
    end

    always_comb begin
        w_lock_state_nxt = UNLOCKED;
        w_beats_nxt      = '0;
        if (w_acc1 && bus.m1_lock) begin
            w_lock_state_nxt = LOCKED;
            w_beats_nxt      = w_lock_active ? (r_beats + C_ONE_BEAT) : C_ONE_BEAT;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mst       <= MST_CPU;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
        end else begin
            r_mem_en <= w_acc0 | w_acc1;
            r_mem_we <= w_acc0 ? bus.m0_we : (w_acc1 & bus.m1_we);
            if (w_acc0) begin
                r_mem_addr  <= bus.m0_addr;
                r_mem_wdata <= bus.m0_wdata;
                r_mst       <= MST_CPU;
            end else if (w_acc1) begin
                r_mem_addr  <= bus.m1_addr;
                r_mem_wdata <= bus.m1_wdata;
                r_mst       <= MST_EXT;
            end
            r_rvalid0 <= r_mem_en & ~r_mem_we & (r_mst == MST_CPU);
            r_rvalid1 <= r_mem_en & ~r_mem_we & (r_mst == MST_EXT);
        end
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.m0_rvalid = r_rvalid0;
    assign bus.m1_rvalid = r_rvalid1;

    // The memory already registers its read port, so its output is valid in the
    // rvalid cycle; gating keeps rdata at zero whenever no response is due.
    assign bus.rdata = (r_rvalid0 | r_rvalid1) ? bus.mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Scoreboard bench for mem_arbiter with a history-based
//               arbitration model and a synchronous memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int C_MAX_LOCK = 8;

    typedef struct {
        int          cyc;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        int          cyc;
        bit          mst;
        logic [31:0] data;
    } rd_t;

    logic clk;
    logic reset;

    mem_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_arbiter #(.AW(32), .DW(32), .MAX_LOCK(C_MAX_LOCK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port synchronous memory, read data valid the cycle after mem_en
    bit [31:0] mem_arr [64];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem_arr[bus.mem_addr[7:2]] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem_arr[bus.mem_addr[7:2]];
        end
    end

    // ---------------- reference model + scoreboard monitor ----------------
    bit [31:0] model_mem [64];
    cmd_t      cmd_q [$];
    rd_t       rd_q  [$];
    int        cyc      = 0;
    int        last_acc = -1;   // -1 none since reset, else master of last accept
    int        burst    = 0;    // length of the current locked m1 burst

    always @(negedge clk) begin
        cmd_t e;
        rd_t  r;
        bit   locked_now, e0, e1;
        cyc++;
        if (!reset) begin
            check({bus.m0_gnt, bus.m1_gnt, bus.mem_en, bus.mem_we, bus.m0_rvalid, bus.m1_rvalid} == 6'b0
                  && bus.mem_addr == 32'h0 && bus.mem_wdata == 32'h0 && bus.rdata == 32'h0,
                  "reset_outputs",
                  {26'h0, bus.m0_gnt, bus.m1_gnt, bus.mem_en, bus.mem_we, bus.m0_rvalid, bus.m1_rvalid,
                   bus.mem_addr | bus.mem_wdata | bus.rdata}, 64'h0);
            cmd_q.delete();
            rd_q.delete();
            last_acc = -1;
            burst    = 0;
        end else begin
            if (bus.mem_en) begin
                check(cmd_q.size() != 0, "mem_en_unexpected", {31'h0, bus.mem_we, bus.mem_addr}, 64'h0);
                if (cmd_q.size() != 0) begin
                    e = cmd_q.pop_front();
                    check(e.cyc == cyc - 1 && bus.mem_we == e.we && bus.mem_addr == e.addr
                          && (!e.we || bus.mem_wdata == e.wdata),
                          "mem_cmd", {bus.mem_we, bus.mem_addr, bus.mem_wdata[30:0]},
                          {e.we, e.addr, e.wdata[30:0]});
                end
            end
            while (cmd_q.size() != 0 && cmd_q[0].cyc < cyc) begin
                e = cmd_q.pop_front();
                check(1'b0 == bus.mem_en, "mem_cmd_missing", 64'(bus.mem_en), 64'h1);
            end

            if (bus.m0_rvalid || bus.m1_rvalid) begin
                check(rd_q.size() != 0, "rvalid_unexpected",
                      {30'h0, bus.m1_rvalid, bus.m0_rvalid, bus.rdata}, 64'h0);
                if (rd_q.size() != 0) begin
                    r = rd_q.pop_front();
                    check(r.cyc == cyc - 2 && bus.m0_rvalid == !r.mst && bus.m1_rvalid == r.mst
                          && bus.rdata == r.data,
                          "read_resp", {30'h0, bus.m1_rvalid, bus.m0_rvalid, bus.rdata},
                          {30'h0, r.mst, !r.mst, r.data});
                end
            end
            while (rd_q.size() != 0 && rd_q[0].cyc <= cyc - 2) begin
                r = rd_q.pop_front();
                check(bus.m0_rvalid || bus.m1_rvalid, "rvalid_missing", 64'h0, 64'(r.data));
            end

            // Expected winner: a live locked burst belongs to m1; otherwise the
            // master that did not win last gets priority (m0 after reset).
            locked_now = burst >= 1 && burst < C_MAX_LOCK && bus.m1_req && bus.m1_lock;
            e0 = 1'b0;
            e1 = 1'b0;
            if (locked_now) begin
                e1 = 1'b1;
            end else if (bus.m0_req && bus.m1_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                e0 = 1'b1;
`else
                e0 = (last_acc != 0);
                e1 = !e0;
`endif
            end else begin
                e0 = bus.m0_req;
                e1 = bus.m1_req;
            end
            check({bus.m0_gnt, bus.m1_gnt} == {e0, e1}, "gnt",
                  {62'h0, bus.m0_gnt, bus.m1_gnt}, {62'h0, e0, e1});

            if (e0) begin
                last_acc = 0;
                cmd_q.push_back('{cyc, bus.m0_we, bus.m0_addr, bus.m0_wdata});
                if (bus.m0_we) model_mem[bus.m0_addr[7:2]] = bus.m0_wdata;
                else rd_q.push_back('{cyc, 1'b0, model_mem[bus.m0_addr[7:2]]});
            end
            if (e1) begin
                last_acc = 1;
                cmd_q.push_back('{cyc, bus.m1_we, bus.m1_addr, bus.m1_wdata});
                if (bus.m1_we) model_mem[bus.m1_addr[7:2]] = bus.m1_wdata;
                else rd_q.push_back('{cyc, 1'b1, model_mem[bus.m1_addr[7:2]]});
            end
            if (e1 && bus.m1_lock) burst = locked_now ? burst + 1 : 1;
            else                   burst = 0;
        end
    end

    // ---------------------------- stimulus ----------------------------
    task automatic issue(input bit mst, input bit we, input logic [31:0] a, input logic [31:0] d);
        bit got = 1'b0;
        if (mst) begin
            bus.m1_req = 1'b1; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
        end else begin
            bus.m0_req = 1'b1; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d;
        end
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = mst ? bus.m1_gnt : bus.m0_gnt;
        end
        check(got, "gnt_wait", 64'(got), 64'h1);
        @(posedge clk); #1;
        if (mst) bus.m1_req = 1'b0;
        else     bus.m0_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        int nbefore, n1, rvcount;
        bit saw0, after, got, g0, g1, p0;
        logic [31:0] capt;

        reset = 1'b0;
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h0; bus.m0_wdata = 32'h0;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h4; bus.m1_wdata = 32'h0;
        bus.m1_lock = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
        @(posedge clk); #1;

        // m0 read of 0x54 holding 7: bus at N+1, response at N+2
        issue(1'b0, 1'b1, 32'h54, 32'h7);
        issue(1'b0, 1'b0, 32'h54, 32'h0);
        @(negedge clk);
        check(bus.mem_en && !bus.mem_we && bus.mem_addr == 32'h54, "read_bus",
              {bus.mem_en, bus.mem_we, bus.mem_addr}, {2'b10, 32'h54});
        @(negedge clk);
        check(bus.m0_rvalid && !bus.m1_rvalid && bus.rdata == 32'h7, "read_data",
              {bus.m0_rvalid, bus.m1_rvalid, bus.rdata}, {2'b10, 32'h7});
        @(posedge clk); #1;

        // Both masters requesting continuously, no lock
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h10;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h20;
        p0 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            g0 = bus.m0_gnt;
            g1 = bus.m1_gnt;
            check((g0 ^ g1) && (k == 0 || g0 != p0), "alternate",
                  {62'h0, g0, g1}, {62'h0, ~p0, p0});
            p0 = g0;
            @(posedge clk); #1;
        end
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
        @(posedge clk); #1;

        // Locked burst of 12 writes, m0 waiting from the second beat
        bus.m1_req = 1'b1; bus.m1_lock = 1'b1; bus.m1_we = 1'b1;
        bus.m1_addr = 32'h80; bus.m1_wdata = 32'h0;
        n1 = 0; nbefore = 0; saw0 = 1'b0; after = 1'b0;
        for (int k = 0; k < 40 && n1 < 12; k++) begin
            @(negedge clk);
            if (bus.m1_gnt) begin
                n1++;
                if (!saw0) nbefore++;
                else       after = 1'b1;
            end
            if (bus.m0_gnt) saw0 = 1'b1;
            @(posedge clk); #1;
            if (saw0) begin
                bus.m0_req = 1'b0;
            end else if (n1 >= 1) begin
                bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h84;
            end
            bus.m1_wdata = 32'(n1);
        end
        bus.m1_req = 1'b0; bus.m1_lock = 1'b0; bus.m0_req = 1'b0;
        check(nbefore == C_MAX_LOCK, "lock_beats", 64'(nbefore), 64'(C_MAX_LOCK));
        check(saw0 && after && n1 == 12, "lock_m0_then_m1", {62'h0, saw0, after}, 64'h3);
        @(posedge clk); #1;

        // m0 write then m1 read of the same address on the next cycle
        issue(1'b0, 1'b1, 32'h50, 32'hA);
        issue(1'b1, 1'b0, 32'h50, 32'h0);
        got = 1'b0;
        capt = 32'h0;
        for (int k = 0; k < 6 && !got; k++) begin
            @(negedge clk);
            if (bus.m1_rvalid) begin
                got  = 1'b1;
                capt = bus.rdata;
            end
        end
        check(got && capt == 32'hA, "write_then_read", {31'h0, got, capt}, {31'h0, 1'b1, 32'hA});
        @(posedge clk); #1;

        // Reset one cycle after a read accept
        issue(1'b0, 1'b0, 32'h54, 32'h0);
        #1 reset = 1'b0;
        #1 check(!bus.mem_en, "reset_kills_mem_en", 64'(bus.mem_en), 64'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        rvcount = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.m0_rvalid || bus.m1_rvalid) rvcount++;
        end
        check(rvcount == 0, "no_rvalid_after_reset", 64'(rvcount), 64'h0);
        @(posedge clk); #1;

        // Randomized traffic, requests held until granted
        g0 = 1'b0;
        g1 = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            g0 = bus.m0_gnt;
            g1 = bus.m1_gnt;
            @(posedge clk); #1;
            if (!bus.m0_req || g0) begin
                bus.m0_req   = ($urandom_range(0, 3) != 0);
                bus.m0_we    = $urandom_range(0, 1) == 1;
                bus.m0_addr  = 32'($urandom_range(0, 63)) << 2;
                bus.m0_wdata = $urandom;
            end
            if (!bus.m1_req || g1) begin
                bus.m1_req   = ($urandom_range(0, 3) != 0);
                bus.m1_we    = $urandom_range(0, 1) == 1;
                bus.m1_addr  = 32'($urandom_range(0, 63)) << 2;
                bus.m1_wdata = $urandom;
            end
            bus.m1_lock = ($urandom_range(0, 2) != 0);
        end
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
        bus.m1_lock = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check(cmd_q.size() == 0 && rd_q.size() == 0, "drain",
              64'(cmd_q.size() + rd_q.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master arbiter sharing the single-port data memory behind the CPU core's data port (dataadr/writedata/memwrite).
- Master 0 = CPU data port; master 1 = loader/debug port that fills or inspects data memory while the core runs.
- Pipelined: one accepted request per cycle, round-robin fairness, optional master-1 burst lock.
- Sits between the core and the data memory inside top.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_LOCK, 8, maximum consecutive master-1 beats while m1_lock is held (≥1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- m0_req  in  1  master 0 request, held until granted.
- m0_we  in  1  master 0 write enable.
- m0_addr  in  AW  master 0 address.
- m0_wdata  in  DW  master 0 write data.
- m0_gnt  out  1  master 0 accept (combinational).
- m0_rvalid  out  1  master 0 read data valid.
- m1_req / m1_we / m1_addr / m1_wdata  in  1/1/AW/DW  master 1 request fields, same as master 0.
- m1_lock  in  1  master 1 burst lock.
- m1_gnt  out  1  master 1 accept (combinational).
- m1_rvalid  out  1  master 1 read data valid.
- rdata  out  DW  shared read data, qualified by m0_rvalid/m1_rvalid.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid the cycle after mem_en & !mem_we.

Behaviour:
- Reset (reset=0, async):
  - mem_en, mem_we, mem_addr, mem_wdata, m0_rvalid, m1_rvalid, rdata all 0.
  - rr pointer = master 0; lock state UNLOCKED; beat count 0.
  - m0_gnt and m1_gnt forced 0 while reset=0.
- Accept:
  - A request is accepted in cycle N when req & gnt.
  - At most one gnt is high per cycle; gnt is never high without the matching req.
- Pipeline:
  - Accepted fields are registered; mem_en/mem_we/mem_addr/mem_wdata are driven in cycle N+1.
  - For a read, rdata = mem_rdata registered, with the matching rvalid high in cycle N+2 for exactly one cycle.
  - Writes produce no rvalid.
  - Back-to-back accepts are allowed every cycle.
- Round-robin:
  - With both requesting, the master named by the rr pointer wins.
  - After any accept, the pointer moves to the other master.
  - A single requester is always granted.
- Lock FSM, states UNLOCKED / LOCKED:
  - UNLOCKED -> LOCKED on an accepted m1 beat with m1_lock=1; beat count = 1.
  - In LOCKED, only m1 may be granted; m0_gnt = 0.
  - Each accepted m1 beat increments the count.
  - LOCKED -> UNLOCKED when m1_lock=0, or when m1_req=0 for a cycle, or after the count reaches MAX_LOCK.
  - On the MAX_LOCK exit, the rr pointer is forced to master 0, so a waiting m0 wins the next cycle even if m1 re-locks.
- Simultaneous events:
  - Lock exit and a new request in the same cycle: arbitration uses the post-exit rules in that same cycle.
  - m1_lock with m1 not granted (m0 wins by rr): no lock entered.
- Reset mid-operation: in-flight accepts and reads are dropped; no rvalid is issued after reset release for pre-reset requests.
- mem_addr/mem_wdata hold their last values when mem_en=0.

Optional Feature:
- MEM_ARB_FIXED_PRIO_EN.
- Defined: master 0 always wins a conflict; the rr pointer is removed. The lock still applies, but the MAX_LOCK exit still yields one m0 win. Starvation of master 1 is permitted.
- Undefined: round-robin as above.

Decomposition:
- Shared package mem_arb_pkg holds:
  - master id typedef (MST_CPU=0, MST_EXT=1);
  - lock state enum (UNLOCKED, LOCKED);
  - localparam for the beat-counter width, $clog2(MAX_LOCK+1).
- One natural sub-module: mem_arb_pick, the combinational grant selector (reqs, rr pointer, lock state -> gnts).
- The pipeline registers and FSM stay in mem_arbiter.

Test Plan:
- Reset/release → all outputs 0; no gnt during reset=0, even with both req=1.
- m0 read addr 0x54 accepted at cycle N, memory returns 7 → mem_en=1 / mem_addr=0x54 at N+1; m0_rvalid=1, rdata=7 at N+2; m1_rvalid stays 0.
- Both masters request continuously, no lock → grants alternate m0, m1, m0, m1; mem_en high every cycle.
- m1 locked burst of 12 writes with MAX_LOCK=8, m0 requesting → 8 m1 beats, 1 m0 grant, then m1 resumes.
- m0 write (addr 0x50, data 0xA) accepted, m1 read of 0x50 accepted next cycle → write is ordered first in memory; m1_rvalid two cycles later returns 0xA.
- reset dropped to 0 one cycle after a read accept → no rvalid ever for that read; mem_en=0 immediately.
